regfile_writeback: RTL and testbench

REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

---
 rtl/regfile_writeback.sv | 157 +++++++++++++++
 tb/tb_regfile_writeback.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback.sv
// Register-file writeback arbiter: ALU results take the single write port first, load results
// wait in an in-order buffer whose entries are killed by younger ALU writes to the same register.
module regfile_writeback #(
  parameter int unsigned DATA_WIDTH         = 32,
  parameter int unsigned NUM_REGISTERS_LOG2 = 5,
  parameter int unsigned FIFO_DEPTH         = 4
) (
  input  logic                          clk,
  input  logic                          reset,

  input  logic                          alu_valid,
  input  logic [NUM_REGISTERS_LOG2-1:0] alu_address,
  input  logic [DATA_WIDTH-1:0]         alu_data,

  input  logic                          load_valid,
  input  logic [NUM_REGISTERS_LOG2-1:0] load_address,
  input  logic [DATA_WIDTH-1:0]         load_data,
  output logic                          load_ready,

  output logic                          write,
  output logic [NUM_REGISTERS_LOG2-1:0] write_address,
  output logic [DATA_WIDTH-1:0]         write_data,

  output logic                          other_write,
  output logic [NUM_REGISTERS_LOG2-1:0] other_write_address,
  output logic [DATA_WIDTH-1:0]         other_write_data,

  input  logic [NUM_REGISTERS_LOG2-1:0] hazard_address,
  output logic                          hazard
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);

  logic [NUM_REGISTERS_LOG2-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]         fifo_data_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]         live_q, live_d;
  logic [PtrW-1:0]               rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]               wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]               count_q, count_d;

  logic                          write_q, write_d;
  logic [NUM_REGISTERS_LOG2-1:0] write_address_q, write_address_d;
  logic [DATA_WIDTH-1:0]         write_data_q, write_data_d;

  logic alu_sel;
  logic push;
  logic pop;

  always_comb begin
    load_ready = !reset && (count_q < DepthCnt);
    alu_sel    = alu_valid && (alu_address != '0);
    // Loads to r0 still handshake but are dropped instead of buffered.
    push       = load_valid && load_ready && (load_address != '0);
    pop        = !alu_sel && (count_q != '0);
  end

  always_comb begin
    live_d = live_q;
    // An ALU write makes every older buffered load to that register dead.
    if (alu_sel) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        if (fifo_addr_q[i] == alu_address) begin
          live_d[i] = 1'b0;
        end
      end
    end
    // Clearing on pop keeps live bits meaningful only for occupied slots.
    if (pop) begin
      live_d[rd_ptr_q] = 1'b0;
    end
    if (push) begin
      live_d[wr_ptr_q] = 1'b1;
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    write_d         = 1'b0;
    write_address_d = write_address_q;
    write_data_d    = write_data_q;
    if (alu_sel) begin
      write_d         = 1'b1;
      write_address_d = alu_address;
      write_data_d    = alu_data;
    end else if (pop && live_q[rd_ptr_q]) begin
      write_d         = 1'b1;
      write_address_d = fifo_addr_q[rd_ptr_q];
      write_data_d    = fifo_data_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      live_q          <= '0;
      rd_ptr_q        <= '0;
      wr_ptr_q        <= '0;
      count_q         <= '0;
      write_q         <= 1'b0;
      write_address_q <= '0;
      write_data_q    <= '0;
    end else begin
      live_q          <= live_d;
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      count_q         <= count_d;
      write_q         <= write_d;
      write_address_q <= write_address_d;
      write_data_q    <= write_data_d;
    end
  end

  // Payload needs no reset: a slot is only read while its live bit or count covers it.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= load_address;
      fifo_data_q[wr_ptr_q] <= load_data;
    end
  end

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
      if (live_q[i] && (fifo_addr_q[i] == hazard_address)) begin
        hazard = 1'b1;
      end
    end
    if (reset || (hazard_address == '0)) begin
      hazard = 1'b0;
    end
  end

  assign write               = write_q;
  assign write_address       = write_address_q;
  assign write_data          = write_data_q;
  assign other_write         = write_q;
  assign other_write_address = write_address_q;
  assign other_write_data    = write_data_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: ALU path, fill/starve, WAW kill, same-edge push,
// address 0, pointer wrap and mid-traffic reset, with hand-computed expectations.
module tb_regfile_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_address;
  logic [31:0] alu_data;
  logic        load_valid;
  logic [4:0]  load_address;
  logic [31:0] load_data;
  logic        load_ready;
  logic        write;
  logic [4:0]  write_address;
  logic [31:0] write_data;
  logic        other_write;
  logic [4:0]  other_write_address;
  logic [31:0] other_write_data;
  logic [4:0]  hazard_address;
  logic        hazard;

  int n_checks = 0;
  int n_pass   = 0;

  regfile_writeback #(
    .DATA_WIDTH        (32),
    .NUM_REGISTERS_LOG2(5),
    .FIFO_DEPTH        (4)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .alu_valid          (alu_valid),
    .alu_address        (alu_address),
    .alu_data           (alu_data),
    .load_valid         (load_valid),
    .load_address       (load_address),
    .load_data          (load_data),
    .load_ready         (load_ready),
    .write              (write),
    .write_address      (write_address),
    .write_data         (write_data),
    .other_write        (other_write),
    .other_write_address(other_write_address),
    .other_write_data   (other_write_data),
    .hazard_address     (hazard_address),
    .hazard             (hazard)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; outputs then reflect that edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid  = 1'b0;
    load_valid = 1'b0;
  endtask

  task automatic check_write(input string tag, input logic w, input logic [4:0] a,
                             input logic [31:0] d);
    check_eq({tag, ".write"}, write, w);
    check_eq({tag, ".addr"}, write_address, a);
    check_eq({tag, ".data"}, write_data, d);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset          = 1'b1;
    alu_valid      = 1'b0;
    alu_address    = '0;
    alu_data       = '0;
    load_valid     = 1'b0;
    load_address   = '0;
    load_data      = '0;
    hazard_address = 5'd5;

    tick();
    tick();
    check_write("reset", 1'b0, 5'd0, 32'd0);
    check_eq("reset.load_ready", load_ready, 1'b0);
    check_eq("reset.hazard", hazard, 1'b0);
    reset = 1'b0;
    #1;
    check_eq("release.load_ready", load_ready, 1'b1);

    // ALU path
    alu_valid = 1'b1; alu_address = 5'd5; alu_data = 32'h1234;
    tick();
    idle();
    check_write("alu", 1'b1, 5'd5, 32'h1234);
    check_eq("alu.other_write", other_write, 1'b1);
    check_eq("alu.other_addr", other_write_address, 5'd5);
    check_eq("alu.other_data", other_write_data, 32'h1234);
    tick();
    check_write("alu.hold", 1'b0, 5'd5, 32'h1234);

    // Fill while ALU starves the drain
    alu_valid = 1'b1; alu_address = 5'd1; alu_data = 32'h55;
    for (int i = 0; i < 5; i++) begin
      load_valid = 1'b1; load_address = 5'(10 + i); load_data = 32'h100 + i;
      #1;
      check_eq($sformatf("fill.ready%0d", i), load_ready, (i < 4));
      tick();
      check_write($sformatf("fill.alu%0d", i), 1'b1, 5'd1, 32'h55);
    end
    hazard_address = 5'd10;
    #1;
    check_eq("fill.hazard10", hazard, 1'b1);
    hazard_address = 5'd14;
    #1;
    check_eq("fill.hazard14", hazard, 1'b0);
    idle();
    for (int i = 0; i < 4; i++) begin
      tick();
      check_write($sformatf("drain%0d", i), 1'b1, 5'(10 + i), 32'h100 + i);
    end
    tick();
    check_eq("drain.done", write, 1'b0);
    check_eq("drain.ready", load_ready, 1'b1);

    // WAW kill
    alu_valid = 1'b1; alu_address = 5'd2; alu_data = 32'h22;
    load_valid = 1'b1; load_address = 5'd7; load_data = 32'hAA;
    hazard_address = 5'd7;
    tick();
    load_valid = 1'b0;
    check_eq("waw.hazard_before", hazard, 1'b1);
    alu_address = 5'd7; alu_data = 32'hBB;
    tick();
    alu_valid = 1'b0;
    check_write("waw.alu", 1'b1, 5'd7, 32'hBB);
    check_eq("waw.hazard_after", hazard, 1'b0);
    tick();
    check_write("waw.dead_pop", 1'b0, 5'd7, 32'hBB);
    tick();
    check_eq("waw.empty", write, 1'b0);

    // Same-edge push and ALU write to r3
    alu_valid = 1'b1; alu_address = 5'd3; alu_data = 32'h22;
    load_valid = 1'b1; load_address = 5'd3; load_data = 32'h11;
    hazard_address = 5'd3;
    tick();
    idle();
    check_write("same.alu", 1'b1, 5'd3, 32'h22);
    check_eq("same.hazard", hazard, 1'b1);
    tick();
    check_write("same.load", 1'b1, 5'd3, 32'h11);
    check_eq("same.hazard_popped", hazard, 1'b0);

    // Address 0 on both paths
    alu_valid = 1'b1; alu_address = 5'd0; alu_data = 32'hDEAD;
    load_valid = 1'b1; load_address = 5'd0; load_data = 32'hBEEF;
    hazard_address = 5'd0;
    tick();
    idle();
    check_eq("r0.write", write, 1'b0);
    check_eq("r0.hazard", hazard, 1'b0);
    tick();
    check_eq("r0.no_push", write, 1'b0);
    check_eq("r0.ready", load_ready, 1'b1);

    // Continuous push/pop across pointer wrap; first push must not pass through
    for (int i = 0; i < 10; i++) begin
      load_valid = 1'b1; load_address = 5'(8 + i); load_data = 32'hC00 + i;
      tick();
      if (i == 0) begin
        check_eq("wrap.no_pass", write, 1'b0);
      end else begin
        check_write($sformatf("wrap%0d", i - 1), 1'b1, 5'(8 + i - 1), 32'hC00 + i - 1);
      end
    end
    idle();
    tick();
    check_write("wrap9", 1'b1, 5'd17, 32'hC09);
    tick();
    check_eq("wrap.empty", write, 1'b0);

    // Reset with three loads buffered behind ALU traffic
    alu_valid = 1'b1; alu_address = 5'd4; alu_data = 32'h44;
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1; load_address = 5'(20 + i); load_data = 32'hE0 + i;
      tick();
    end
    hazard_address = 5'd21;
    #1;
    check_eq("rst.hazard_before", hazard, 1'b1);
    reset = 1'b1;
    #1;
    check_eq("rst.write_now", write, 1'b0);
    check_eq("rst.ready_now", load_ready, 1'b0);
    check_eq("rst.hazard_now", hazard, 1'b0);
    tick();
    idle();
    reset = 1'b0;
    #1;
    check_eq("rst.ready_after", load_ready, 1'b1);
    tick();
    check_write("rst.no_stale0", 1'b0, 5'd0, 32'd0);
    tick();
    check_eq("rst.no_stale1", write, 1'b0);
    check_eq("rst.hazard_after", hazard, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
